// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, deferred redirect under stall, IF/ID pipeline register.
// imem_address is combinational from pc; IF/ID is one cycle; stall holds pc and IF/ID.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        misaligned
);

    logic [31:0] r_pc;
    logic        r_pending;
    logic [31:0] r_pending_target;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic [31:0] r_id_instruction;
    logic        r_id_valid;
    logic        r_misaligned;

    logic [31:0] w_target_aligned;
    logic [31:0] w_pc_plus4;
    logic        w_take_redirect;
    logic        w_take_pending;
    logic        w_pc_loaded;
    logic [31:0] w_pc_nxt;
    logic        w_pending_nxt;
    logic [31:0] w_pending_target_nxt;

    assign w_target_aligned = {redirect_target[31:2], 2'b00};
    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_take_redirect  = redirect_valid & ~stall;
    assign w_take_pending   = ~redirect_valid & r_pending & ~stall;
    // A PC loaded from a redirect means the word fetched this cycle is wrong-path.
    assign w_pc_loaded      = w_take_redirect | w_take_pending;

    always_comb begin
        w_pc_nxt             = r_pc;
        w_pending_nxt        = r_pending;
        w_pending_target_nxt = r_pending_target;
        if (w_take_redirect) begin
            w_pc_nxt      = w_target_aligned;
            w_pending_nxt = 1'b0;
        end else if (redirect_valid) begin
            w_pending_nxt        = 1'b1;
            w_pending_target_nxt = w_target_aligned;
        end else if (w_take_pending) begin
            w_pc_nxt      = r_pending_target;
            w_pending_nxt = 1'b0;
        end else if (!stall) begin
            w_pc_nxt = w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc             <= RESET_PC;
            r_pending        <= 1'b0;
            r_pending_target <= 32'd0;
            r_misaligned     <= 1'b0;
        end else begin
            r_pc             <= w_pc_nxt;
            r_pending        <= w_pending_nxt;
            r_pending_target <= w_pending_target_nxt;
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id_pc          <= 32'd0;
            r_id_pc_plus4    <= 32'd0;
            r_id_instruction <= 32'd0;
            r_id_valid       <= 1'b0;
        end else if (flush || (!stall && w_pc_loaded)) begin
            r_id_pc          <= 32'd0;
            r_id_pc_plus4    <= 32'd0;
            r_id_instruction <= 32'd0;
            r_id_valid       <= 1'b0;
        end else if (!stall) begin
            r_id_pc          <= r_pc;
            r_id_pc_plus4    <= w_pc_plus4;
            r_id_instruction <= imem_instruction;
            r_id_valid       <= 1'b1;
        end
    end

    assign imem_address   = r_pc;
    assign id_pc          = r_id_pc;
    assign id_pc_plus4    = r_id_pc_plus4;
    assign id_instruction = r_id_instruction;
    assign id_valid       = r_id_valid;
    assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then randomized traffic vs. a reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(.RESET_PC(32'h00000000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .id_instruction   (id_instruction),
        .id_valid         (id_valid),
        .misaligned       (misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_of(input logic [31:0] a);
        if (a == 32'd0) return 32'h20040003;
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    assign imem_instruction = imem_of(imem_address);

    // Reference state: architectural view of the fetch stage.
    logic [31:0] m_pc, m_ptgt, m_id_pc, m_id_pc4, m_id_ins;
    logic        m_pend, m_id_vld, m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_pend = 1'b0; m_ptgt = 32'd0; m_mis = 1'b0;
        m_id_pc = 32'd0; m_id_pc4 = 32'd0; m_id_ins = 32'd0; m_id_vld = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_address"}, imem_address, m_pc);
        chk({tag, ".id_pc"}, id_pc, m_id_pc);
        chk({tag, ".id_pc_plus4"}, id_pc_plus4, m_id_pc4);
        chk({tag, ".id_instruction"}, id_instruction, m_id_ins);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_id_vld});
        chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, m_mis});
    endtask

    // One clock edge: predict from the pre-edge inputs, then compare after the edge.
    task automatic step(input string tag);
        logic [31:0] tgt, n_pc;
        logic        wrong_path;
        tgt = redirect_target & 32'hFFFF_FFFC;
        wrong_path = 1'b0;
        n_pc = m_pc;
        if (redirect_valid && !stall) begin
            n_pc = tgt; m_pend = 1'b0; wrong_path = 1'b1;
        end else if (redirect_valid) begin
            m_pend = 1'b1; m_ptgt = tgt;
        end else if (m_pend && !stall) begin
            n_pc = m_ptgt; m_pend = 1'b0; wrong_path = 1'b1;
        end else if (!stall) begin
            n_pc = m_pc + 32'd4;
        end
        if (flush || (!stall && wrong_path)) begin
            m_id_pc = 0; m_id_pc4 = 0; m_id_ins = 0; m_id_vld = 0;
        end else if (!stall) begin
            m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_ins = imem_of(m_pc); m_id_vld = 1;
        end
        if (redirect_valid && redirect_target[1:0] != 2'b00) m_mis = 1'b1;
        m_pc = n_pc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] tgt);
        stall = st; flush = fl; redirect_valid = rv; redirect_target = tgt;
    endtask

    // Pulse reset between edges, check immediately, release before the next edge.
    task automatic mid_reset(input string tag);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all(tag);
        #2 reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        step("seq1");
        chk("seq.id_pc", id_pc, 32'h0);
        chk("seq.id_pc_plus4", id_pc_plus4, 32'h4);
        chk("seq.id_instruction", id_instruction, 32'h20040003);
        chk("seq.imem_address", imem_address, 32'h4);

        step("seq2");
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall");
            chk("stall.imem_address", imem_address, 32'h8);
        end
        drive(0, 0, 0, 0);
        step("unstall");
        chk("unstall.id_pc", id_pc, 32'h8);
        step("to10");
        chk("to10.pc", imem_address, 32'h10);

        drive(0, 0, 1, 32'h0C);
        step("redir");
        chk("redir.imem_address", imem_address, 32'h0C);
        chk("redir.id_valid", {31'd0, id_valid}, 32'd0);
        drive(0, 0, 0, 0);
        step("redir2");
        chk("redir2.id_pc", id_pc, 32'h0C);

        drive(0, 0, 1, 32'h20);
        step("to20");
        drive(1, 0, 1, 32'h40);
        step("stredir");
        chk("stredir.pc_held", imem_address, 32'h20);
        drive(1, 0, 0, 0);
        step("stredir2");
        chk("stredir2.pc_held", imem_address, 32'h20);
        drive(0, 0, 0, 0);
        step("stredir3");
        chk("stredir3.pc", imem_address, 32'h40);
        chk("stredir3.bubble", {31'd0, id_valid}, 32'd0);

        drive(0, 0, 1, 32'h13);
        step("mis");
        chk("mis.pc", imem_address, 32'h10);
        chk("mis.flag", {31'd0, misaligned}, 32'd1);
        drive(0, 0, 1, 32'hFFFF_FFFC);
        step("wrap1");
        drive(0, 0, 0, 0);
        step("wrap2");
        chk("wrap.pc", imem_address, 32'h0);
        chk("wrap.id_pc_plus4", id_pc_plus4, 32'h0);
        chk("wrap.mis_sticky", {31'd0, misaligned}, 32'd1);

        drive(1, 0, 1, 32'h80);
        step("pend");
        drive(0, 0, 0, 0);
        mid_reset("areset");
        step("after_reset");
        chk("after_reset.id_pc", id_pc, 32'h0);
        chk("after_reset.id_valid", {31'd0, id_valid}, 32'd1);
        chk("after_reset.pc", imem_address, 32'h4);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 2, t);
            if ($urandom_range(0, 199) == 0) begin
                mid_reset("rnd_reset");
            end else begin
                step("rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
